multi_ctrl: RTL and testbench

MULTI_CTRL -- requirements
Module: multi_ctrl

---
 rtl/multi_ctrl_pkg.sv | 71 +++++++
 rtl/multi_ctrl_dec.sv | 50 +++++
 rtl/multi_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multi_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// FSM states, ALU operation codes, opcode/funct values and control bundle.
package multi_ctrl_pkg;

    localparam logic [4:0] S_IF  = 5'd0;
    localparam logic [4:0] S_ID  = 5'd1;
    localparam logic [4:0] S_MA  = 5'd2;
    localparam logic [4:0] S_MRD = 5'd3;
    localparam logic [4:0] S_LWB = 5'd4;
    localparam logic [4:0] S_MWR = 5'd5;
    localparam logic [4:0] S_REX = 5'd6;
    localparam logic [4:0] S_RWB = 5'd7;
    localparam logic [4:0] S_BR  = 5'd8;
    localparam logic [4:0] S_JMP = 5'd9;
    localparam logic [4:0] S_IEX = 5'd10;
    localparam logic [4:0] S_IWB = 5'd11;
    localparam logic [4:0] S_LUI = 5'd12;
    localparam logic [4:0] S_JAL = 5'd13;
    localparam logic [4:0] S_JR  = 5'd14;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       pcwrite;
        logic       pcwritecond;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multi_ctrl_dec.sv
// Combinational instruction decode: ALU operation, dispatch state out of ID,
// and whether the instruction is one whose overflow suppresses write-back.
module multi_ctrl_dec
    import multi_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic [4:0] dispatch,
    output logic       arith
);

    always_comb begin
        alu_op   = ALU_ADD;
        dispatch = S_IF;
        arith    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dispatch = S_REX;
                case (funct)
                    FN_ADD: arith = 1'b1;
                    FN_SUB: begin alu_op = ALU_SUB; arith = 1'b1; end
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_XOR: alu_op = ALU_XOR;
                    FN_NOR: alu_op = ALU_NOR;
                    FN_SLT: alu_op = ALU_SLT;
                    FN_SRL: alu_op = ALU_SRL;
                    FN_JR:  dispatch = S_JR;
                    default: dispatch = S_IF;
                endcase
            end
            OP_LW, OP_SW: dispatch = S_MA;
            OP_BEQ, OP_BNE: begin
                alu_op   = ALU_SUB;
                dispatch = S_BR;
            end
            OP_ADDI: begin dispatch = S_IEX; arith = 1'b1; end
            OP_ANDI: begin dispatch = S_IEX; alu_op = ALU_AND; end
            OP_ORI:  begin dispatch = S_IEX; alu_op = ALU_OR;  end
            OP_XORI: begin dispatch = S_IEX; alu_op = ALU_XOR; end
            OP_SLTI: begin dispatch = S_IEX; alu_op = ALU_SLT; end
            OP_LUI:  dispatch = S_LUI;
            OP_J:    dispatch = S_JMP;
            OP_JAL:  dispatch = S_JAL;
            default: dispatch = S_IF;
        endcase
    end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle controller FSM: Moore control outputs per state, with the
// ALU operation and branch sense taken from the instruction decode.
module multi_ctrl
    import multi_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_in,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic [4:0]  state_out
);

    logic [4:0] state;
    logic [4:0] state_nx;
    logic       ovf;
    logic [2:0] dec_op;
    logic [4:0] dec_disp;
    logic       dec_arith;
    ctrl_t      c;

    // zero is consumed by the datapath together with PCWriteCond/Branch
    logic unused_bits;
    assign unused_bits = ^{zero, Inst_in[25:6]};

    multi_ctrl_dec u_dec (
        .opcode   (Inst_in[31:26]),
        .funct    (Inst_in[5:0]),
        .alu_op   (dec_op),
        .dispatch (dec_disp),
        .arith    (dec_arith)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IF;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_REX || state == S_IEX)
                ovf <= overflow & dec_arith;
        end
    end

    always_comb begin
        state_nx = S_IF;
        case (state)
            S_IF:  state_nx = MIO_ready ? S_ID : S_IF;
            S_ID:  state_nx = dec_disp;
            S_MA:  state_nx = (Inst_in[31:26] == OP_SW) ? S_MWR : S_MRD;
            S_MRD: state_nx = MIO_ready ? S_LWB : S_MRD;
            S_MWR: state_nx = MIO_ready ? S_IF : S_MWR;
            S_REX: state_nx = S_RWB;
            S_IEX: state_nx = S_IWB;
            default: state_nx = S_IF;
        endcase
    end

    always_comb begin
        c = '0;
        case (state)
            S_IF: begin
                c.iord     = 1'b1;
                c.memread  = 1'b1;
                c.irwrite  = 1'b1;
                c.alusrca  = 1'b1;
                c.alusrcb  = 2'b01;
                c.alu_op   = ALU_ADD;
                c.pcwrite  = 1'b1;
            end
            S_ID: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b11;
                c.alu_op  = ALU_ADD;
            end
            S_MA: begin
                c.alusrcb = 2'b10;
                c.alu_op  = ALU_ADD;
            end
            S_MRD: begin
                c.alusrcb = 2'b10;
                c.alu_op  = ALU_ADD;
                c.memread = 1'b1;
            end
            S_MWR: begin
                c.alusrcb  = 2'b10;
                c.alu_op   = ALU_ADD;
                c.memwrite = 1'b1;
            end
            S_LWB: begin
                c.memtoreg = 2'b01;
                c.regwrite = 1'b1;
            end
            S_REX: c.alu_op = dec_op;
            S_RWB: begin
                c.alu_op   = dec_op;
                c.regdst   = 2'b01;
                c.regwrite = ~ovf;
            end
            S_IEX: begin
                c.alusrcb = 2'b10;
                c.alu_op  = dec_op;
            end
            S_IWB: c.regwrite = ~ovf;
            S_BR: begin
                c.alu_op      = ALU_SUB;
                c.pcsource    = 2'b01;
                c.pcwritecond = 1'b1;
                c.branch      = (Inst_in[31:26] == OP_BEQ);
            end
            S_JMP: begin
                c.pcsource = 2'b10;
                c.pcwrite  = 1'b1;
            end
            S_JAL: begin
                c.pcsource = 2'b10;
                c.pcwrite  = 1'b1;
                c.regdst   = 2'b10;
                c.memtoreg = 2'b11;
                c.regwrite = 1'b1;
            end
            S_JR: begin
                c.alu_op  = ALU_ADD;
                c.pcwrite = 1'b1;
            end
            S_LUI: begin
                c.memtoreg = 2'b10;
                c.regwrite = 1'b1;
            end
            default: c = '0;
        endcase
    end

    // write enables are held off for as long as reset is high
    assign IorD          = c.iord;
    assign IRWrite       = c.irwrite & ~reset;
    assign RegWrite      = c.regwrite & ~reset;
    assign ALUSrcA       = c.alusrca;
    assign PCWrite       = c.pcwrite & ~reset;
    assign PCWriteCond   = c.pcwritecond & ~reset;
    assign Branch        = c.branch;
    assign MemRead       = c.memread & ~reset;
    assign MemWrite      = c.memwrite & ~reset;
    assign CPU_MIO       = MemRead | MemWrite;
    assign RegDst        = c.regdst;
    assign MemtoReg      = c.memtoreg;
    assign ALUSrcB       = c.alusrcb;
    assign PCSource      = c.pcsource;
    assign ALU_operation = c.alu_op;
    assign state_out     = state;

endmodule

// File: tb/tb_multi_ctrl.sv
// Bench for multi_ctrl: CPI table, directed corner sequences and a random
// instruction stream checked against an instruction-level reference model.
module tb_multi_ctrl;
    import multi_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Inst_in;
    logic        zero, overflow, MIO_ready;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond;
    logic        Branch, MemRead, MemWrite, CPU_MIO;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic [4:0]  state_out;
    logic [20:0] obs;

    int vectors = 0;
    int miscompares = 0;
    bit m_ovf = 1'b0;

    multi_ctrl dut (
        .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero),
        .overflow(overflow), .MIO_ready(MIO_ready), .IorD(IorD),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
        .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALU_operation(ALU_operation),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    assign obs = {IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond,
                  Branch, MemRead, MemWrite, CPU_MIO, RegDst, MemtoReg,
                  ALUSrcB, PCSource, ALU_operation};

    typedef struct {
        logic [31:0] ins;
        int          cpi;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_arith(input logic [31:0] ins);
        return (ins[31:26] == 6'h00 && (ins[5:0] == 6'h20 || ins[5:0] == 6'h22))
            || ins[31:26] == 6'h08;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [31:0] ins);
        logic [2:0] a;
        a = 3'b010;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h22: a = 3'b110;
                6'h24: a = 3'b000;
                6'h25: a = 3'b001;
                6'h26: a = 3'b011;
                6'h27: a = 3'b100;
                6'h2A: a = 3'b111;
                6'h02: a = 3'b101;
                default: a = 3'b010;
            endcase
        end else begin
            case (ins[31:26])
                6'h0C: a = 3'b000;
                6'h0D: a = 3'b001;
                6'h0E: a = 3'b011;
                6'h0A: a = 3'b111;
                default: a = 3'b010;
            endcase
        end
        return a;
    endfunction

    // Expected control word for a given step of an instruction
    function automatic logic [20:0] exp_ctl(input logic [4:0] st,
                                            input logic [31:0] ins, input bit ov);
        logic iord, irw, rw, asa, pcw, pcwc, br, mr, mw;
        logic [1:0] rd, m2r, asb, pcs;
        logic [2:0] alu;
        {iord, irw, rw, asa, pcw, pcwc, br, mr, mw} = 9'b0;
        {rd, m2r, asb, pcs} = 8'b0;
        alu = 3'b000;
        case (st)
            S_IF:  begin iord = 1; mr = 1; irw = 1; asa = 1; asb = 2'b01;
                         alu = 3'b010; pcw = 1; end
            S_ID:  begin asa = 1; asb = 2'b11; alu = 3'b010; end
            S_MA:  begin asb = 2'b10; alu = 3'b010; end
            S_MRD: begin asb = 2'b10; alu = 3'b010; mr = 1; end
            S_MWR: begin asb = 2'b10; alu = 3'b010; mw = 1; end
            S_LWB: begin m2r = 2'b01; rw = 1; end
            S_REX: alu = ref_alu(ins);
            S_RWB: begin alu = ref_alu(ins); rd = 2'b01; rw = !ov; end
            S_IEX: begin asb = 2'b10; alu = ref_alu(ins); end
            S_IWB: rw = !ov;
            S_BR:  begin alu = 3'b110; pcs = 2'b01; pcwc = 1;
                         br = (ins[31:26] == 6'h04); end
            S_JMP: begin pcs = 2'b10; pcw = 1; end
            S_JAL: begin pcs = 2'b10; pcw = 1; rd = 2'b10; m2r = 2'b11; rw = 1; end
            S_JR:  begin alu = 3'b010; pcw = 1; end
            S_LUI: begin m2r = 2'b10; rw = 1; end
            default: ;
        endcase
        return {iord, irw, rw, asa, pcw, pcwc, br, mr, mw, mr | mw,
                rd, m2r, asb, pcs, alu};
    endfunction

    // Reference model: instruction class -> ordered list of steps
    task automatic run_instr(input logic [31:0] ins, input int stall_pct);
        logic [4:0] ph[$];
        logic [5:0] op, fn;
        int stalls;
        op = ins[31:26];
        fn = ins[5:0];
        ph.push_back(S_IF);
        ph.push_back(S_ID);
        case (op)
            6'h00: begin
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02}) begin
                    ph.push_back(S_REX);
                    ph.push_back(S_RWB);
                end else if (fn == 6'h08) ph.push_back(S_JR);
            end
            6'h23: begin ph.push_back(S_MA); ph.push_back(S_MRD); ph.push_back(S_LWB); end
            6'h2B: begin ph.push_back(S_MA); ph.push_back(S_MWR); end
            6'h04, 6'h05: ph.push_back(S_BR);
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                ph.push_back(S_IEX);
                ph.push_back(S_IWB);
            end
            6'h0F: ph.push_back(S_LUI);
            6'h02: ph.push_back(S_JMP);
            6'h03: ph.push_back(S_JAL);
            default: ;
        endcase
        foreach (ph[i]) begin
            stalls = 0;
            forever begin
                @(negedge clk);
                Inst_in   = ins;
                overflow  = 1'($urandom_range(1));
                zero      = 1'($urandom_range(1));
                MIO_ready = (stalls >= 4) || ($urandom_range(99) >= stall_pct);
                #1;
                chk("rnd_state", 32'(state_out), 32'(ph[i]));
                chk("rnd_ctl", 32'(obs), 32'(exp_ctl(ph[i], ins, m_ovf)));
                if (ph[i] == S_REX || ph[i] == S_IEX)
                    m_ovf = overflow && is_arith(ins);
                if (!(ph[i] inside {S_IF, S_MRD, S_MWR}) || MIO_ready) break;
                stalls++;
            end
        end
    endtask

    // Step until IF is observed, then hold it there
    task automatic settle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (state_out == S_IF) begin
                MIO_ready = 1'b0;
                return;
            end
            MIO_ready = 1'b1;
        end
        chk("settle_timeout", 32'(state_out), 32'(S_IF));
    endtask

    task automatic advance_to(input logic [31:0] ins, input logic [4:0] target,
                              input logic ov);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            Inst_in  = ins;
            overflow = ov;
            if (state_out == target) return;
            MIO_ready = 1'b1;
        end
        chk("reach_timeout", 32'(state_out), 32'(target));
    endtask

    task automatic measure_cpi(input logic [31:0] ins, output int n);
        @(negedge clk);
        #1;
        Inst_in   = ins;
        MIO_ready = 1'b1;
        overflow  = 1'b0;
        n = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (state_out == S_IF) begin
                MIO_ready = 1'b0;
                return;
            end
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int n;
        logic [31:0] r, ins;
        logic [5:0] ops[$];
        logic [5:0] fns[$];

        tbl.push_back('{32'h8C220004, 5});
        tbl.push_back('{32'hAC220004, 4});
        tbl.push_back('{32'h00430820, 4});
        tbl.push_back('{32'h00430822, 4});
        tbl.push_back('{32'h00430824, 4});
        tbl.push_back('{32'h00430827, 4});
        tbl.push_back('{32'h0043082A, 4});
        tbl.push_back('{32'h00430842, 4});
        tbl.push_back('{32'h03E00008, 3});
        tbl.push_back('{32'h10220003, 3});
        tbl.push_back('{32'h14220003, 3});
        tbl.push_back('{32'h20220004, 4});
        tbl.push_back('{32'h3422000F, 4});
        tbl.push_back('{32'h28220004, 4});
        tbl.push_back('{32'h3C011234, 3});
        tbl.push_back('{32'h08000010, 3});
        tbl.push_back('{32'h0C000010, 3});
        tbl.push_back('{32'hFC000000, 2});
        tbl.push_back('{32'h00430801, 2});

        reset = 1'b1;
        Inst_in = 32'h0;
        zero = 1'b0;
        overflow = 1'b0;
        MIO_ready = 1'b1;

        // Reset, then release into IF -> ID
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", 32'(state_out), 32'(S_IF));
        chk("rst_pcwrite", 32'(PCWrite), 32'd0);
        chk("rst_enables", 32'({IRWrite, RegWrite, MemRead, MemWrite, CPU_MIO}), 32'd0);
        reset = 1'b0;
        #1;
        chk("if_pcwrite", 32'(PCWrite), 32'd1);
        chk("if_memread", 32'(CPU_MIO), 32'd1);
        @(negedge clk);
        #1;
        chk("if_to_id", 32'(state_out), 32'(S_ID));
        @(negedge clk);
        #1;
        chk("undef_to_if", 32'(state_out), 32'(S_IF));
        MIO_ready = 1'b0;

        foreach (tbl[i]) begin
            measure_cpi(tbl[i].ins, n);
            chk($sformatf("cpi_%08h", tbl[i].ins), 32'(n), 32'(tbl[i].cpi));
        end

        // bne and beq in BR
        advance_to(32'h14220003, S_BR, 1'b0);
        chk("bne_ctl", 32'({PCWriteCond, Branch, PCSource, ALU_operation}),
            32'({1'b1, 1'b0, 2'b01, 3'b110}));
        settle();
        advance_to(32'h10220003, S_BR, 1'b0);
        chk("beq_branch", 32'(Branch), 32'd1);
        settle();

        // jal
        advance_to(32'h0C000010, S_JAL, 1'b0);
        chk("jal_ctl", 32'({RegDst, MemtoReg, PCSource, PCWrite, RegWrite}),
            32'({2'b10, 2'b11, 2'b10, 1'b1, 1'b1}));
        settle();

        // add with and without overflow
        advance_to(32'h00430820, S_REX, 1'b0);
        overflow = 1'b1;
        advance_to(32'h00430820, S_RWB, 1'b1);
        chk("add_ovf_regwrite", 32'(RegWrite), 32'd0);
        settle();
        advance_to(32'h00430820, S_RWB, 1'b0);
        chk("add_ok_regwrite", 32'({RegWrite, RegDst}), 32'({1'b1, 2'b01}));
        settle();
        advance_to(32'h20220004, S_IEX, 1'b0);
        overflow = 1'b1;
        advance_to(32'h20220004, S_IWB, 1'b1);
        chk("addi_ovf_regwrite", 32'(RegWrite), 32'd0);
        settle();

        // sw stalled three cycles in MWR
        advance_to(32'hAC220004, S_MWR, 1'b0);
        MIO_ready = 1'b0;
        #1;
        chk("sw_stall0", 32'({MemWrite, CPU_MIO}), 32'd3);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("sw_stall_state", 32'(state_out), 32'(S_MWR));
            chk("sw_stall_mw", 32'(MemWrite), 32'd1);
        end
        @(negedge clk);
        #1;
        MIO_ready = 1'b1;
        #1;
        chk("sw_last_state", 32'(state_out), 32'(S_MWR));
        chk("sw_last_mw", 32'(MemWrite), 32'd1);
        @(negedge clk);
        #1;
        chk("sw_done_if", 32'(state_out), 32'(S_IF));
        MIO_ready = 1'b0;

        // reset during MWR aborts the store
        advance_to(32'hAC220004, S_MWR, 1'b0);
        MIO_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mwr_mw", 32'({MemWrite, CPU_MIO}), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mwr_if", 32'(state_out), 32'(S_IF));
        MIO_ready = 1'b0;

        // random stream against the reference model
        ops = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                6'h0E, 6'h0F, 6'h02, 6'h03, 6'h01, 6'h3F, 6'h00, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02,
                6'h08, 6'h01, 6'h3F};
        for (int t = 0; t < 300; t++) begin
            r = $urandom();
            ins = {ops[$urandom_range(ops.size() - 1)], r[25:0]};
            if (ins[31:26] == 6'h00)
                ins[5:0] = fns[$urandom_range(fns.size() - 1)];
            run_instr(ins, 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
